// File: rtl/rr_lane_pkg.sv
// Shared types and helpers for the round-robin lane arbiter.
// Optional burst limiting is selected with RR_LANE_BURST_LIMIT_EN.
package rr_lane_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam int N_DEF         = 3;
   localparam int MAX_BURST_DEF = 4;

   function automatic logic [31:0] onehot(input int idx, input int n);
      logic [31:0] v;
      v = '0;
      if (idx >= 0 && idx < n && idx < 32) v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/rr_lane_arbiter_pick.sv
// Combinational round-robin picker: first set req after ptr, wrapping.
// The current pointer position is scanned last.
module rr_pick
   import rr_lane_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic          any,
   output logic [PW-1:0] winner
);

   logic [PW-1:0] sel;

   // Walk the scan order backwards so the earliest candidate wins.
   always_comb begin
      any    = 1'b0;
      winner = '0;
      sel    = '0;
      for (int k = N; k >= 1; k--) begin
         sel = PW'((int'(ptr) + k) % N);
         if (req[sel]) begin
            any    = 1'b1;
            winner = sel;
         end
      end
   end

endmodule

// File: rtl/rr_lane_arbiter.sv
// Round-robin sequencer sharing one serial lane among N requesters.
// Define RR_LANE_BURST_LIMIT_EN to cap each grant at MAX_BURST cycles.
module rr_lane_arbiter
   import rr_lane_pkg::*;
#(
   parameter int N         = N_DEF,
   parameter int MAX_BURST = MAX_BURST_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic [N-1:0] din,
   output logic [N-1:0] gnt,
   output logic         q,
   output logic         q_vld,
   output logic         busy
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   if (N < 1 || MAX_BURST < 1) begin : g_cfg_err
      $error("rr_lane_arbiter: N and MAX_BURST must be >= 1");
   end

   state_t        state;
   logic [PW-1:0] ptr;
   logic          any;
   logic [PW-1:0] winner;

   rr_pick #(
      .N  (N),
      .PW (PW)
   ) u_pick (
      .req    (req),
      .ptr    (ptr),
      .any    (any),
      .winner (winner)
   );

`ifdef RR_LANE_BURST_LIMIT_EN
   localparam int CW = $clog2(MAX_BURST + 1);
   logic [CW-1:0] burst_cnt;
   logic          burst_end;
   assign burst_end = (burst_cnt == CW'(MAX_BURST - 1));
`else
   logic          burst_end;
   assign burst_end = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         gnt   <= '0;
         ptr   <= PW'(N - 1);
`ifdef RR_LANE_BURST_LIMIT_EN
         burst_cnt <= '0;
`endif
      end else begin
         unique case (state)
            IDLE, GAP: begin
               if (any) begin
                  state <= GRANT;
                  gnt   <= N'(onehot(int'(winner), N));
                  ptr   <= winner;
`ifdef RR_LANE_BURST_LIMIT_EN
                  burst_cnt <= '0;
`endif
               end else begin
                  state <= IDLE;
                  gnt   <= '0;
               end
            end
            GRANT: begin
               // Voluntary drop and forced expiry both cost one dead cycle.
               if (!req[ptr] || burst_end) begin
                  state <= GAP;
                  gnt   <= '0;
               end else begin
`ifdef RR_LANE_BURST_LIMIT_EN
                  burst_cnt <= burst_cnt + 1'b1;
`endif
               end
            end
            default: begin
               state <= IDLE;
               gnt   <= '0;
            end
         endcase
      end
   end

   assign q     = |(gnt & din);
   assign q_vld = |(gnt & req);
   assign busy  = (state != IDLE);

endmodule

// File: tb/tb_rr_lane_arbiter.sv
// Directed vector table plus corner sequences and a random soak
// for rr_lane_arbiter (N=3, MAX_BURST=4).
module tb_rr_lane_arbiter;

   localparam int N  = 3;
   localparam int MB = 4;

   logic         clk;
   logic         rst;
   logic [N-1:0] req;
   logic [N-1:0] din;
   logic [N-1:0] gnt;
   logic         q;
   logic         q_vld;
   logic         busy;

   int checks;
   int failures;

   rr_lane_arbiter #(
      .N         (N),
      .MAX_BURST (MB)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .din   (din),
      .gnt   (gnt),
      .q     (q),
      .q_vld (q_vld),
      .busy  (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [2:0] req;
      logic [2:0] din;
      logic [2:0] gnt;
      logic       q;
      logic       vld;
      logic       busy;
   } vec_t;

   vec_t       tv[23];
   logic [2:0] exp_b[11];
   logic [2:0] exp_s[10];

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      din = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst = 1'b1;
      req = '0;
      din = '0;

      tv[0]  = '{3'b111, 3'b000, 3'b000, 0, 0, 0};
      tv[1]  = '{3'b111, 3'b001, 3'b001, 1, 1, 1};
      tv[2]  = '{3'b110, 3'b001, 3'b001, 1, 0, 1};
      tv[3]  = '{3'b110, 3'b111, 3'b000, 0, 0, 1};
      tv[4]  = '{3'b100, 3'b010, 3'b010, 1, 0, 1};
      tv[5]  = '{3'b100, 3'b000, 3'b000, 0, 0, 1};
      tv[6]  = '{3'b100, 3'b100, 3'b100, 1, 1, 1};
      tv[7]  = '{3'b000, 3'b100, 3'b100, 1, 0, 1};
      tv[8]  = '{3'b000, 3'b000, 3'b000, 0, 0, 1};
      tv[9]  = '{3'b000, 3'b000, 3'b000, 0, 0, 0};
      tv[10] = '{3'b010, 3'b000, 3'b000, 0, 0, 0};
      tv[11] = '{3'b010, 3'b010, 3'b010, 1, 1, 1};
      tv[12] = '{3'b010, 3'b000, 3'b010, 0, 1, 1};
      tv[13] = '{3'b000, 3'b010, 3'b010, 1, 0, 1};
      tv[14] = '{3'b000, 3'b000, 3'b000, 0, 0, 1};
      tv[15] = '{3'b000, 3'b000, 3'b000, 0, 0, 0};
      tv[16] = '{3'b011, 3'b000, 3'b000, 0, 0, 0};
      tv[17] = '{3'b000, 3'b000, 3'b001, 0, 0, 1};
      tv[18] = '{3'b000, 3'b000, 3'b000, 0, 0, 1};
      tv[19] = '{3'b001, 3'b000, 3'b000, 0, 0, 0};
      tv[20] = '{3'b000, 3'b001, 3'b001, 1, 0, 1};
      tv[21] = '{3'b000, 3'b000, 3'b000, 0, 0, 1};
      tv[22] = '{3'b000, 3'b000, 3'b000, 0, 0, 0};

`ifdef RR_LANE_BURST_LIMIT_EN
      exp_b = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000,
                3'b100, 3'b100, 3'b100, 3'b100, 3'b000,
                3'b001};
      exp_s = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b000,
                3'b100, 3'b100, 3'b100, 3'b100, 3'b000};
`else
      foreach (exp_b[i]) exp_b[i] = 3'b001;
      foreach (exp_s[i]) exp_s[i] = 3'b100;
`endif

      #1;
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_q", 32'(q), 0);
      chk("rst_vld", 32'(q_vld), 0);
      chk("rst_busy", 32'(busy), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int r = 0; r < 23; r++) begin
         req = tv[r].req;
         din = tv[r].din;
         #1;
         chk($sformatf("v%0d_gnt", r), 32'(gnt), 32'(tv[r].gnt));
         chk($sformatf("v%0d_q", r), 32'(q), 32'(tv[r].q));
         chk($sformatf("v%0d_vld", r), 32'(q_vld), 32'(tv[r].vld));
         chk($sformatf("v%0d_busy", r), 32'(busy), 32'(tv[r].busy));
         cyc();
      end

      // async reset in the middle of a grant
      req = 3'b001;
      din = 3'b001;
      cyc();
      chk("pre_rst_gnt", 32'(gnt), 32'(3'b001));
      #2;
      rst = 1'b1;
      #1;
      chk("arst_gnt", 32'(gnt), 0);
      chk("arst_q", 32'(q), 0);
      chk("arst_vld", 32'(q_vld), 0);
      chk("arst_busy", 32'(busy), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      req = 3'b110;
      din = 3'b000;
      #1;
      chk("post_rst_idle", 32'(gnt), 0);
      cyc();
      chk("post_rst_gnt", 32'(gnt), 32'(3'b010));
      req = '0;
      cyc();
      cyc();

      // burst behaviour with two competing requesters
      do_reset();
      req = 3'b101;
      cyc();
      for (int c = 0; c < 11; c++) begin
         chk($sformatf("burst_c%0d", c), 32'(gnt), 32'(exp_b[c]));
         cyc();
      end

      // sole requester must not hang
      do_reset();
      req = 3'b100;
      cyc();
      for (int c = 0; c < 10; c++) begin
         chk($sformatf("sole_c%0d", c), 32'(gnt), 32'(exp_s[c]));
         cyc();
      end

      // random soak
      do_reset();
      begin
         logic [2:0] prev_req;
         logic [2:0] prev_gnt;
         int         wt[N];
         int         wmax;
         logic       eq;
         logic       ev;
         prev_req = '0;
         prev_gnt = '0;
         foreach (wt[i]) wt[i] = 0;
         for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < N; i++)
               if ($urandom_range(3) == 0) req[i] = ~req[i];
            din = 3'($urandom);
            #1;
            eq = 1'b0;
            ev = 1'b0;
            for (int i = 0; i < N; i++)
               if (gnt[i]) begin
                  eq = din[i];
                  ev = req[i];
               end
            chk("rnd_onehot", 32'($countones(gnt) <= 1), 1);
            chk("rnd_q", 32'(q), 32'(eq));
            chk("rnd_vld", 32'(q_vld), 32'(ev));
            if (gnt != prev_gnt && gnt != '0)
               chk("rnd_gnt_req", 32'(|(gnt & prev_req)), 1);
            wmax = 0;
            for (int i = 0; i < N; i++) begin
               if (req[i] && !gnt[i]) wt[i]++;
               else wt[i] = 0;
               if (wt[i] > wmax) wmax = wt[i];
            end
`ifdef RR_LANE_BURST_LIMIT_EN
            chk("rnd_wait", 32'(wmax <= (N - 1) * (MB + 1) + 1), 1);
`endif
            prev_req = req;
            prev_gnt = gnt;
            cyc();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
